// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: ops, shifter commands, entry-mux codes, states.
package shift_seq_pkg;

    localparam int unsigned AMT_W   = 5;
    localparam int unsigned LUI_AMT = 16;

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SRA  = 3'b010,
        OP_SLLV = 3'b011,
        OP_SRLV = 3'b100,
        OP_SRAV = 3'b101,
        OP_LUI  = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        SH_NOP  = 3'b000,
        SH_LOAD = 3'b001,
        SH_SLL  = 3'b010,
        SH_SRL  = 3'b011,
        SH_SRA  = 3'b100
    } sh_e;

    typedef enum logic [1:0] {
        ENT_IMM = 2'b00,
        ENT_B   = 2'b01,
        ENT_A   = 2'b10
    } ent_e;

    typedef enum logic [1:0] {
        AMT_SRC_NONE  = 2'b00,
        AMT_SRC_SHAMT = 2'b01,
        AMT_SRC_RS    = 2'b10,
        AMT_SRC_LUI   = 2'b11
    } amt_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_WB    = 2'b11
    } state_e;

    typedef struct packed {
        ent_e     entry;
        sh_e      shift;
        amt_src_e amt_src;
    } op_dec_t;

endpackage

// File: rtl/shift_op_decode.sv
// Pure combinational map from an op code to entry-mux select, shift command and amount source.
module shift_op_decode
    import shift_seq_pkg::*;
(
    input  logic [2:0] op,
    output op_dec_t    dec
);

    always_comb begin
        dec.entry   = ENT_B;
        dec.shift   = SH_NOP;
        dec.amt_src = AMT_SRC_NONE;
        case (op)
            OP_SLL:  begin dec.shift = SH_SLL; dec.amt_src = AMT_SRC_SHAMT; end
            OP_SRL:  begin dec.shift = SH_SRL; dec.amt_src = AMT_SRC_SHAMT; end
            OP_SRA:  begin dec.shift = SH_SRA; dec.amt_src = AMT_SRC_SHAMT; end
            OP_SLLV: begin dec.shift = SH_SLL; dec.amt_src = AMT_SRC_RS;    end
            OP_SRLV: begin dec.shift = SH_SRL; dec.amt_src = AMT_SRC_RS;    end
            OP_SRAV: begin dec.shift = SH_SRA; dec.amt_src = AMT_SRC_RS;    end
            OP_LUI:  begin
                dec.entry   = ENT_IMM;
                dec.shift   = SH_SLL;
                dec.amt_src = AMT_SRC_LUI;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences the shift register and its entry mux through IDLE/LOAD/SHIFT/WB.
// Optional SHIFT_ITER_EN: shift one bit per cycle, counting the latched amount down.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] shamt,
    input  logic [AMT_W-1:0] rs_amt,
    output logic [1:0]       entry_ctrl,
    output logic [2:0]       shift_ctrl,
    output logic [AMT_W-1:0] shift_n,
    output logic             busy,
    output logic             done
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [2:0]       r_op;
    logic [2:0]       w_op_nxt;
    logic [AMT_W-1:0] r_amt;
    logic [AMT_W-1:0] w_amt_nxt;
    logic             w_accept;
    op_dec_t          w_dec;

    logic [1:0]       r_entry;
    logic [2:0]       r_shift;
    logic [AMT_W-1:0] r_shift_n;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       w_entry_nxt;
    logic [2:0]       w_shift_nxt;
    logic [AMT_W-1:0] w_shift_n_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

`ifdef SHIFT_ITER_EN
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_cnt_nxt;
`endif

    // Decode the op that will be held next cycle so outputs can be registered.
    assign w_accept = (r_state == ST_IDLE) && start && (op != OP_ILL);
    assign w_op_nxt = w_accept ? op : r_op;

    shift_op_decode u_decode (
        .op  (w_op_nxt),
        .dec (w_dec)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_amt_nxt   = r_amt;
`ifdef SHIFT_ITER_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_LOAD;
                    case (w_dec.amt_src)
                        AMT_SRC_SHAMT: w_amt_nxt = shamt;
                        AMT_SRC_RS:    w_amt_nxt = rs_amt;
                        AMT_SRC_LUI:   w_amt_nxt = AMT_W'(LUI_AMT);
                        default:       w_amt_nxt = r_amt;
                    endcase
                end
            end
            ST_LOAD: begin
`ifdef SHIFT_ITER_EN
                w_cnt_nxt   = r_amt;
                w_state_nxt = (r_amt == '0) ? ST_WB : ST_SHIFT;
`else
                w_state_nxt = ST_SHIFT;
`endif
            end
            ST_SHIFT: begin
`ifdef SHIFT_ITER_EN
                w_cnt_nxt   = r_cnt - AMT_W'(1);
                w_state_nxt = (r_cnt <= AMT_W'(1)) ? ST_WB : ST_SHIFT;
`else
                w_state_nxt = ST_WB;
`endif
            end
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs of the upcoming state, registered so they line up with it.
    always_comb begin
        w_entry_nxt   = 2'b00;
        w_shift_nxt   = 3'b000;
        w_shift_n_nxt = '0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (w_state_nxt)
            ST_LOAD: begin
                w_entry_nxt = w_dec.entry;
                w_shift_nxt = SH_LOAD;
                w_busy_nxt  = 1'b1;
            end
            ST_SHIFT: begin
                w_entry_nxt   = w_dec.entry;
                w_shift_nxt   = w_dec.shift;
`ifdef SHIFT_ITER_EN
                w_shift_n_nxt = AMT_W'(1);
`else
                w_shift_n_nxt = w_amt_nxt;
`endif
                w_busy_nxt    = 1'b1;
            end
            ST_WB: begin
                w_entry_nxt = w_dec.entry;
                w_busy_nxt  = 1'b1;
                w_done_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_amt     <= '0;
            r_entry   <= '0;
            r_shift   <= '0;
            r_shift_n <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SHIFT_ITER_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_amt     <= w_amt_nxt;
            r_entry   <= w_entry_nxt;
            r_shift   <= w_shift_nxt;
            r_shift_n <= w_shift_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
`ifdef SHIFT_ITER_EN
            r_cnt     <= w_cnt_nxt;
`endif
        end
    end

    assign entry_ctrl = r_entry;
    assign shift_ctrl = r_shift;
    assign shift_n    = r_shift_n;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (default build) with a behavioural 32-bit shifter attached.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [4:0] shamt;
    logic [4:0] rs_amt;
    logic [1:0] entry_ctrl;
    logic [2:0] shift_ctrl;
    logic [4:0] shift_n;
    logic       busy;
    logic       done;

    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [15:0] imm16;
    logic [31:0] sh_reg;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    int          done_base;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .shamt      (shamt),
        .rs_amt     (rs_amt),
        .entry_ctrl (entry_ctrl),
        .shift_ctrl (shift_ctrl),
        .shift_n    (shift_n),
        .busy       (busy),
        .done       (done)
    );

    // Stand-in for the shift register and its entry mux.
    always @(posedge clk) begin
        case (shift_ctrl)
            3'b001: sh_reg <= (entry_ctrl == 2'b00) ? {16'h0, imm16} :
                              (entry_ctrl == 2'b01) ? reg_b : reg_a;
            3'b010: sh_reg <= sh_reg << shift_n;
            3'b011: sh_reg <= sh_reg >> shift_n;
            3'b100: sh_reg <= $signed(sh_reg) >>> shift_n;
            default: ;
        endcase
        if (done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ent, input logic [2:0] sh,
                              input logic [4:0] n, input logic bsy, input logic dn);
        check({tag, ".entry"}, 32'(entry_ctrl), 32'(ent));
        check({tag, ".shift"}, 32'(shift_ctrl), 32'(sh));
        check({tag, ".n"},     32'(shift_n),    32'(n));
        check({tag, ".busy"},  32'(busy),       32'(bsy));
        check({tag, ".done"},  32'(done),       32'(dn));
    endtask

    task automatic issue(input logic [2:0] o, input logic [4:0] sa, input logic [4:0] ra);
        start  = 1'b1;
        op     = o;
        shamt  = sa;
        rs_amt = ra;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        shamt  = '0;
        rs_amt = '0;
        reg_a  = '0;
        reg_b  = '0;
        imm16  = '0;
        tick();
        tick();
        check_outs("reset", 2'b00, 3'b000, 5'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_outs("idle", 2'b00, 3'b000, 5'd0, 1'b0, 1'b0);

        // SLL by 4 on B
        reg_b = 32'h0000_000F;
        done_base = n_done;
        issue(3'b000, 5'd4, 5'd9);
        check_outs("sll.load", 2'b01, 3'b001, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("sll.shift", 2'b01, 3'b010, 5'd4, 1'b1, 1'b0);
        tick();
        check("sll.wb.done", 32'(done), 32'd1);
        check("sll.wb.shift", 32'(shift_ctrl), 32'd0);
        check("sll.wb.busy", 32'(busy), 32'd1);
        check("sll.result", sh_reg, 32'h0000_00F0);
        tick();
        check_outs("sll.idle", 2'b00, 3'b000, 5'd0, 1'b0, 1'b0);
        check("sll.ndone", 32'(n_done - done_base), 32'd1);

        // SRAV by rs_amt=8; operand changes after latching must not matter
        reg_a = 32'h8000_0000;
        reg_b = 32'h8000_0000;
        issue(3'b101, 5'd3, 5'd8);
        rs_amt = 5'd1;
        shamt  = 5'd7;
        op     = 3'b000;
        check_outs("srav.load", 2'b01, 3'b001, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("srav.shift", 2'b01, 3'b100, 5'd8, 1'b1, 1'b0);
        tick();
        check("srav.wb.done", 32'(done), 32'd1);
        check("srav.result", sh_reg, 32'hFF80_0000);
        tick();

        // LUI: immediate path, fixed amount 16, done three cycles after start
        imm16 = 16'h1234;
        reg_b = 32'hDEAD_BEEF;
        issue(3'b110, 5'd2, 5'd3);
        check_outs("lui.load", 2'b00, 3'b001, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("lui.shift", 2'b00, 3'b010, 5'd16, 1'b1, 1'b0);
        tick();
        check("lui.wb.done", 32'(done), 32'd1);
        check("lui.result", sh_reg, 32'h1234_0000);

        // Back-to-back: start in the IDLE cycle right after WB, amount 0 still shifts
        tick();
        check("b2b.idle.busy", 32'(busy), 32'd0);
        reg_b = 32'h0000_0055;
        issue(3'b011, 5'd9, 5'd0);
        check_outs("sllv0.load", 2'b01, 3'b001, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("sllv0.shift", 2'b01, 3'b010, 5'd0, 1'b1, 1'b0);
        tick();
        check("sllv0.wb.done", 32'(done), 32'd1);
        check("sllv0.result", sh_reg, 32'h0000_0055);
        tick();

        // Illegal op is ignored; start while busy is ignored
        done_base = n_done;
        issue(3'b111, 5'd4, 5'd4);
        check_outs("ill.idle", 2'b00, 3'b000, 5'd0, 1'b0, 1'b0);
        reg_b = 32'h0000_00F0;
        issue(3'b001, 5'd2, 5'd6);
        start = 1'b1;
        op    = 3'b000;
        shamt = 5'd31;
        check_outs("srl.load", 2'b01, 3'b001, 5'd0, 1'b1, 1'b0);
        tick();
        check_outs("srl.shift", 2'b01, 3'b011, 5'd2, 1'b1, 1'b0);
        tick();
        check("srl.wb.done", 32'(done), 32'd1);
        check("srl.result", sh_reg, 32'h0000_003C);
        start = 1'b0;
        tick();
        tick();
        check_outs("srl.idle", 2'b00, 3'b000, 5'd0, 1'b0, 1'b0);
        check("busy.ndone", 32'(n_done - done_base), 32'd1);

        // Reset held two cycles while in SHIFT
        done_base = n_done;
        issue(3'b010, 5'd5, 5'd0);
        tick();
        check("rst.pre.shift", 32'(shift_ctrl), 32'd4);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_outs("rst.mid", 2'b00, 3'b000, 5'd0, 1'b0, 1'b0);
        tick();
        check_outs("rst.after", 2'b00, 3'b000, 5'd0, 1'b0, 1'b0);
        tick();
        check("rst.ndone", 32'(n_done - done_base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
